// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares a single uart_tx instance between two byte producers
//   (A: CPU I/O port, B: debug monitor). A round-robin grant picks one
//   requester, latches its byte into tx_data and raises tx_send. The
//   arbiter then follows the uart_tx handshake:
//     - hold tx_send until tx_ready falls (uart_tx took the byte),
//     - drop tx_send and wait for tx_ready to rise again (frame done).
//   Only one byte is in flight at a time. Each granted requester sees a
//   single-cycle ack pulse. All outputs are registered.
//
// Configuration:
//   UART_ARB_TIMEOUT_EN - when defined, a 16-bit counter bounds the time
//                         tx_send may stay high without tx_ready falling.
//                         On expiry the byte is dropped, tx_send is released
//                         and the sticky timeout_err flag is set.
//                         When undefined, S_START waits indefinitely and
//                         timeout_err is held at 0.
//
// Parameters:
//   TIMEOUT_CYCLES  number of S_START cycles allowed before a timeout
//                   (only meaningful with UART_ARB_TIMEOUT_EN)
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  asynchronous reset, active-high
//   a_req        in   1  requester A has a byte (hold with a_data until a_ack)
//   a_data       in   8  requester A byte
//   a_ack        out  1  one-cycle pulse: a_data latched
//   b_req        in   1  requester B has a byte (hold with b_data until b_ack)
//   b_data       in   8  requester B byte
//   b_ack        out  1  one-cycle pulse: b_data latched
//   tx_data      out  8  byte to uart_tx
//   tx_send      out  1  send strobe to uart_tx
//   tx_ready     in   1  ready from uart_tx
//   busy         out  1  high whenever the arbiter is not idle
//   owner        out  1  requester of the last granted byte (0=A, 1=B)
//   timeout_err  out  1  sticky timeout flag (0 unless UART_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------

module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_ready,
    output logic       busy,
    output logic       owner,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t     state_q,       state_d;
    logic [7:0] tx_data_q,     tx_data_d;
    logic       tx_send_q,     tx_send_d;
    logic       a_ack_q,       a_ack_d;
    logic       b_ack_q,       b_ack_d;
    logic       busy_q,        busy_d;
    logic       owner_q,       owner_d;
    logic       timeout_err_q, timeout_err_d;

    // Arbitration helpers (combinational)
    logic       any_req;
    logic       grant_b;

`ifdef UART_ARB_TIMEOUT_EN
    // Counter value seen on the last permitted S_START cycle: the counter
    // starts at 0 on the first S_START cycle, so TIMEOUT_CYCLES-1 marks the
    // TIMEOUT_CYCLES-th cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
    // Parameter is only consumed by the timeout build.
    logic [15:0] unused_timeout_limit;
    assign unused_timeout_limit = 16'(TIMEOUT_CYCLES);
`endif

    // Round-robin choice: a lone requester wins; with both pending the one
    // that did not own the previous byte wins (strict alternation).
    always_comb begin
        any_req = a_req | b_req;
        grant_b = b_req & (~a_req | ~owner_q);
    end

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_send_d     = tx_send_q;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        owner_d       = owner_q;
        timeout_err_d = timeout_err_q;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // tx_ready low here means uart_tx is still in reset or
                // finishing; requests are simply held off.
                if (tx_ready && any_req) begin
                    state_d   = S_START;
                    tx_send_d = 1'b1;
                    owner_d   = grant_b;
                    tx_data_d = grant_b ? b_data : a_data;
                    a_ack_d   = ~grant_b;
                    b_ack_d   = grant_b;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end else begin
                    state_d   = S_IDLE;
                    tx_send_d = 1'b0;
                end
            end

            S_START: begin
                if (!tx_ready) begin
                    // uart_tx has taken the byte; release the strobe so it
                    // can leave its stop-bit state later.
                    state_d   = S_BUSY;
                    tx_send_d = 1'b0;
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (tmo_cnt_q == TIMEOUT_LAST) begin
                        // Byte was already acked, so it is dropped here.
                        state_d       = S_IDLE;
                        tx_send_d     = 1'b0;
                        timeout_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d     = tmo_cnt_q + 16'd1;
                        tx_send_d     = 1'b1;
                    end
`else
                    tx_send_d = 1'b1;
`endif
                end
            end

            S_BUSY: begin
                tx_send_d = 1'b0;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end

            default: begin
                state_d   = S_IDLE;
                tx_send_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);

`ifndef UART_ARB_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
    end

    // State and output registers; reset forces the idle, no-ack condition
    // immediately, abandoning any byte in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tx_data_q     <= 8'h00;
            tx_send_q     <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b1;
            timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_send_q     <= tx_send_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed testbench for uart_tx_arbiter. A small behavioural uart_tx
// responder drops tx_ready when it sees tx_send, logs the byte, stays busy
// for FRAME cycles and only re-asserts tx_ready once tx_send is low. The
// responder can be bypassed so tx_ready can be forced directly.
// -----------------------------------------------------------------------------

module tb_uart_tx_arbiter;

    localparam int FRAME   = 6;
    localparam int TMO_CYC = 16;

    logic       clk;
    logic       reset;
    logic       a_req;
    logic [7:0] a_data;
    logic       a_ack;
    logic       b_req;
    logic [7:0] b_data;
    logic       b_ack;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_ready;
    logic       busy;
    logic       owner;
    logic       timeout_err;

    // uart_tx responder
    logic       model_en;
    logic       ready_force;
    logic       model_ready;
    int         model_cnt;
    logic [7:0] sent_q[$];

    // ack monitor
    int         a_acks;
    int         b_acks;
    int         both_acks;

    int         n_vec;
    int         n_err;

    uart_tx_arbiter #(
        .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_data     (a_data),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_data     (b_data),
        .b_ack      (b_ack),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_ready = model_en ? model_ready : ready_force;

    // Behavioural uart_tx handshake responder.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_ready <= 1'b1;
            model_cnt   <= 0;
        end else if (model_en) begin
            if (model_ready) begin
                if (tx_send) begin
                    model_ready <= 1'b0;
                    model_cnt   <= FRAME;
                    sent_q.push_back(tx_data);
                end
            end else if (model_cnt > 0) begin
                model_cnt <= model_cnt - 1;
            end else if (!tx_send) begin
                model_ready <= 1'b1;
            end
        end
    end

    // Ack pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_ack) a_acks <= a_acks + 1;
            if (b_ack) b_acks <= b_acks + 1;
            if (a_ack && b_ack) both_acks <= both_acks + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        sent_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            step();
            cyc++;
        end
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ack(input string tag);
        int cyc;
        cyc = 0;
        while (!(a_ack || b_ack) && cyc < 100) begin
            step();
            cyc++;
        end
        check_val(tag, {31'd0, a_ack | b_ack}, 32'd1);
    endtask

    // Requesters hold req and advance data on each ack; idle_gaps counts
    // samples with the arbiter idle while bytes are still pending.
    task automatic run_stream(input int na, input logic [7:0] a_first, input logic [7:0] a_step,
                              input int nb, input logic [7:0] b_first, input logic [7:0] b_step,
                              output int idle_gaps);
        int ia;
        int ib;
        int cyc;
        ia = 0;
        ib = 0;
        cyc = 0;
        idle_gaps = 0;
        a_req  = (na > 0);
        a_data = a_first;
        b_req  = (nb > 0);
        b_data = b_first;
        while ((ia < na || ib < nb || busy) && cyc < 2000) begin
            step();
            cyc++;
            if (a_ack) begin
                check_val("owner_on_a_ack", {31'd0, owner}, 32'd0);
                ia++;
                a_data = a_data + a_step;
                if (ia == na) a_req = 1'b0;
            end
            if (b_ack) begin
                check_val("owner_on_b_ack", {31'd0, owner}, 32'd1);
                ib++;
                b_data = b_data + b_step;
                if (ib == nb) b_req = 1'b0;
            end
            if (!busy && (ia < na || ib < nb)) idle_gaps++;
        end
        check_val("stream_done", {31'd0, cyc < 2000}, 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int a0;
        int b0;
        int hi;
        logic [7:0] exp_b;

        n_vec       = 0;
        n_err       = 0;
        a_acks      = 0;
        b_acks      = 0;
        both_acks   = 0;
        model_en    = 1'b1;
        ready_force = 1'b1;
        a_req       = 1'b0;
        a_data      = 8'h00;
        b_req       = 1'b0;
        b_data      = 8'h00;
        reset       = 1'b1;

        // ---- reset state ----
        repeat (3) step();
        check_val("rst_tx_send",     {31'd0, tx_send},     32'd0);
        check_val("rst_tx_data",     {24'd0, tx_data},     32'h00);
        check_val("rst_busy",        {31'd0, busy},        32'd0);
        check_val("rst_owner",       {31'd0, owner},       32'd1);
        check_val("rst_acks",        {30'd0, a_ack, b_ack}, 32'd0);
        check_val("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;

        // ---- 1: single A byte, one-edge latency ----
        a_req  = 1'b1;
        a_data = 8'h41;
        step();
        check_val("t1_a_ack",   {31'd0, a_ack},   32'd1);
        check_val("t1_b_ack",   {31'd0, b_ack},   32'd0);
        check_val("t1_tx_send", {31'd0, tx_send}, 32'd1);
        check_val("t1_tx_data", {24'd0, tx_data}, 32'h41);
        check_val("t1_busy",    {31'd0, busy},    32'd1);
        check_val("t1_owner",   {31'd0, owner},   32'd0);
        a_req = 1'b0;
        step();
        check_val("t1_ack_pulse", {31'd0, a_ack}, 32'd0);
        wait_idle("t1_idle");
        check_val("t1_frames", sent_q.size(), 32'd1);
        if (sent_q.size() > 0) check_val("t1_byte", {24'd0, sent_q[0]}, 32'h41);

        // ---- 2: both requesting, strict alternation from reset ----
        do_reset();
        a0 = a_acks;
        b0 = b_acks;
        run_stream(3, 8'h31, 8'h00, 3, 8'h32, 8'h00, gaps);
        check_val("t2_frames", sent_q.size(), 32'd6);
        for (int i = 0; i < sent_q.size() && i < 6; i++) begin
            check_val("t2_order", {24'd0, sent_q[i]}, (i % 2 == 0) ? 32'h31 : 32'h32);
        end
        check_val("t2_a_acks", a_acks - a0, 32'd3);
        check_val("t2_b_acks", b_acks - b0, 32'd3);

        // ---- 3: B only, advancing data, back-to-back gap ----
        sent_q.delete();
        run_stream(0, 8'h00, 8'h00, 4, 8'h00, 8'h01, gaps);
        check_val("t3_frames", sent_q.size(), 32'd4);
        for (int i = 0; i < sent_q.size() && i < 4; i++) begin
            exp_b = 8'(i);
            check_val("t3_byte", {24'd0, sent_q[i]}, {24'd0, exp_b});
        end
        check_val("t3_idle_gaps", gaps, 32'd3);

        // ---- 6: a_req pulsed for one cycle while busy ----
        sent_q.delete();
        a0 = a_acks;
        b_req  = 1'b1;
        b_data = 8'h5a;
        wait_ack("t6_b_ack");
        b_req = 1'b0;
        step();
        a_req  = 1'b1;
        a_data = 8'h99;
        step();
        a_req = 1'b0;
        wait_idle("t6_idle");
        repeat (3) step();
        check_val("t6_no_a_ack", a_acks - a0, 32'd0);
        check_val("t6_frames",   sent_q.size(), 32'd1);

        // ---- tx_ready low while idle: requests held off ----
        model_en    = 1'b0;
        ready_force = 1'b0;
        a0 = a_acks;
        a_req  = 1'b1;
        a_data = 8'h10;
        repeat (5) step();
        check_val("hold_no_ack",  a_acks - a0,        32'd0);
        check_val("hold_busy",    {31'd0, busy},      32'd0);
        check_val("hold_tx_send", {31'd0, tx_send},   32'd0);
        a_req = 1'b0;
        step();

        // ---- 5: tx_ready stuck high after a grant ----
        ready_force = 1'b1;
        a_req  = 1'b1;
        a_data = 8'h77;
        wait_ack("t5_ack");
        a_req = 1'b0;
        hi = tx_send ? 1 : 0;
        repeat (40) begin
            step();
            if (tx_send) hi++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        check_val("t5_send_cycles", hi,                    TMO_CYC);
        check_val("t5_timeout_err", {31'd0, timeout_err},  32'd1);
        check_val("t5_busy",        {31'd0, busy},         32'd0);
`else
        check_val("t5_send_cycles", hi,                    32'd41);
        check_val("t5_timeout_err", {31'd0, timeout_err},  32'd0);
        check_val("t5_busy",        {31'd0, busy},         32'd1);
`endif
        ready_force = 1'b0;
        repeat (2) step();
        ready_force = 1'b1;
        wait_idle("t5_recover_idle");
        model_en = 1'b1;
        sent_q.delete();
        run_stream(1, 8'h78, 8'h00, 0, 8'h00, 8'h00, gaps);
        check_val("t5_next_frames", sent_q.size(), 32'd1);
        if (sent_q.size() > 0) check_val("t5_next_byte", {24'd0, sent_q[0]}, 32'h78);
`ifdef UART_ARB_TIMEOUT_EN
        check_val("t5_sticky", {31'd0, timeout_err}, 32'd1);
`else
        check_val("t5_sticky", {31'd0, timeout_err}, 32'd0);
`endif

        // ---- 4: reset in the middle of a frame ----
        a_req  = 1'b1;
        a_data = 8'h55;
        wait_ack("t4_ack");
        a_req = 1'b0;
        repeat (3) step();
        check_val("t4_busy_mid", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("t4_tx_send",    {31'd0, tx_send},      32'd0);
        check_val("t4_busy",       {31'd0, busy},         32'd0);
        check_val("t4_acks",       {30'd0, a_ack, b_ack}, 32'd0);
        check_val("t4_owner",      {31'd0, owner},        32'd1);
        check_val("t4_tx_data",    {24'd0, tx_data},      32'h00);
        check_val("t4_timeout_err", {31'd0, timeout_err}, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        sent_q.delete();
        run_stream(1, 8'h66, 8'h00, 0, 8'h00, 8'h00, gaps);
        check_val("t4_after_frames", sent_q.size(), 32'd1);
        if (sent_q.size() > 0) check_val("t4_after_byte", {24'd0, sent_q[0]}, 32'h66);

        step();
        check_val("never_both_acks", both_acks, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
